// File: rtl/frame_sequencer_if.sv
`timescale 1ns/1ps
// Control/status bundle between the frame sequencer and its surroundings:
// FIFO gating, pooled-output handshake and frame status.
interface frame_sequencer_if;
    logic        start;
    logic        abort;
    logic        fifo_empty_in;
    logic        fifo_empty_gated;
    logic        fifo_rd_en;
    logic        pooled_valid;
    logic        pooled_ready_in;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;
    logic [2:0]  state;
    logic [19:0] in_count;
    logic [19:0] out_count;

    modport master (
        output start, abort, fifo_empty_in, fifo_rd_en,
        output pooled_valid, pooled_ready_in,
        input  fifo_empty_gated, busy, frame_done, timeout_err,
        input  state, in_count, out_count
    );

    modport slave (
        input  start, abort, fifo_empty_in, fifo_rd_en,
        input  pooled_valid, pooled_ready_in,
        output fifo_empty_gated, busy, frame_done, timeout_err,
        output state, in_count, out_count
    );
endinterface

// File: rtl/frame_sequencer.sv
`timescale 1ns/1ps
// Frame sequencer: admits exactly one frame of FIFO reads, counts pooled
// output bytes, and fails the frame if the datapath stalls.
module frame_sequencer #(
    parameter int unsigned IN_PIXELS   = 307200,
    parameter int unsigned OUT_PIXELS  = 76800,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic             clk_200mhz,
    input  logic             reset_n,
    frame_sequencer_if.slave bus
);
    localparam int unsigned WD_W =
        (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [19:0]     CNT_MAX = 20'hFFFFF;
    localparam logic [19:0]     IN_LAST = 20'(IN_PIXELS - 1);
    localparam logic [20:0]     OUT_TGT = 21'(OUT_PIXELS);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t          r_state;
    state_t          w_next;
    logic [19:0]     r_in_count;
    logic [19:0]     r_out_count;
    logic [WD_W-1:0] r_wd;
    logic            r_frame_done;

    logic            w_active;
    logic            w_gated;
    logic            w_rd_fire;
    logic            w_out_fire;
    logic            w_launch;
    logic            w_in_done;
    logic            w_out_reached;
    logic            w_wd_expire;
    logic [20:0]     w_out_sum;

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_gated    = bus.fifo_empty_in || (r_state != S_RUN);
    assign w_rd_fire  = bus.fifo_rd_en && !w_gated;
    assign w_out_fire = bus.pooled_valid && bus.pooled_ready_in && w_active;
    assign w_launch   = bus.start && !w_active;
    assign w_in_done  = w_rd_fire && (r_in_count >= IN_LAST);

    // Completion looks at the count including this cycle's transfer.
    assign w_out_sum     = {1'b0, r_out_count} + 21'(w_out_fire);
    assign w_out_reached = (w_out_sum >= OUT_TGT);
    assign w_wd_expire   = !w_rd_fire && !w_out_fire && (r_wd >= WD_LAST);

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) w_next = S_RUN;
                end
                S_RUN: begin
                    if (w_in_done)        w_next = S_DRAIN;
                    else if (w_wd_expire) w_next = S_ERR;
                end
                S_DRAIN: begin
                    if (w_out_reached)    w_next = S_DONE;
                    else if (w_wd_expire) w_next = S_ERR;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_in_count   <= '0;
            r_out_count  <= '0;
            r_wd         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (bus.abort || w_launch) begin
                r_in_count  <= '0;
                r_out_count <= '0;
            end else begin
                if (w_rd_fire && (r_in_count != CNT_MAX))
                    r_in_count <= r_in_count + 20'd1;
                if (w_out_fire && (r_out_count != CNT_MAX))
                    r_out_count <= r_out_count + 20'd1;
            end

            // Watchdog restarts on any progress or any state change.
            if (!w_active || (w_next != r_state) || w_rd_fire || w_out_fire)
                r_wd <= '0;
            else
                r_wd <= r_wd + WD_W'(1);

            r_frame_done <= (w_next == S_DONE) && (r_state != S_DONE);
        end
    end

    always_comb begin
        bus.fifo_empty_gated = w_gated;
        bus.busy             = w_active;
        bus.timeout_err      = (r_state == S_ERR);
        bus.frame_done       = r_frame_done;
        bus.state            = r_state;
        bus.in_count         = r_in_count;
        bus.out_count        = r_out_count;
    end
endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
  IN_PIXELS    307200  bytes read from the async FIFO per frame (640x480)
  OUT_PIXELS   76800   pooled bytes expected per frame
  TIMEOUT_CYC  65535   cycles with no handshake before the frame is declared failed
REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
  clk_200mhz        in   1   single clock, all logic on rising edge
  reset_n           in   1   asynchronous, active-low reset
  start             in   1   frame start request (level sampled each cycle)
  abort             in   1   cancel current frame
  fifo_empty_in     in   1   empty flag from the async FIFO
  fifo_empty_gated  out  1   empty flag presented to the FIFO reader
  fifo_rd_en        in   1   read enable from the FIFO reader
  pooled_valid      in   1   pooling output valid
  pooled_ready_in   in   1   downstream ready (parallel2serial)
  busy              out  1   frame in progress
  frame_done        out  1   one-cycle completion pulse
  timeout_err       out  1   frame failed (level)
  state             out  3   current state encoding
  in_count          out  20  bytes read this frame
  out_count         out  20  pooled bytes delivered this frame

Function
REQ-003 SHALL implement states IDLE=0, RUN=1, DRAIN=2, DONE=3, ERR=4; state output is the registered encoding.
REQ-004 SHALL drive fifo_empty_gated = fifo_empty_in OR (state != RUN), combinationally, with zero latency.
REQ-005 SHALL define rd_fire = fifo_rd_en AND NOT fifo_empty_gated; in_count SHALL increment by 1 per rd_fire.
REQ-006 SHALL define out_fire = pooled_valid AND pooled_ready_in; out_count SHALL increment by 1 per out_fire only in RUN or DRAIN; out_fire in IDLE/DONE/ERR SHALL be ignored.
REQ-007 SHALL saturate both counters at 2^20-1; no wrap-around.
REQ-008 IDLE/DONE/ERR -> RUN on start=1; same edge clears in_count, out_count, watchdog, timeout_err.
REQ-009 start in RUN or DRAIN SHALL be ignored.
REQ-010 RUN -> DRAIN on the edge where rd_fire takes in_count to IN_PIXELS; exactly IN_PIXELS reads per frame, never more.
REQ-011 DRAIN -> DONE on the edge where out_count (including a same-cycle out_fire) reaches OUT_PIXELS or is already at/above it.
REQ-012 out_count reaching OUT_PIXELS while in RUN SHALL NOT end the frame; DRAIN then exits to DONE on its first cycle.
REQ-013 rd_fire and out_fire in the same cycle SHALL both be counted.
REQ-014 watchdog SHALL count cycles in RUN/DRAIN; clear on rd_fire, out_fire or any state change; on reaching TIMEOUT_CYC -> ERR.
REQ-015 ERR SHALL hold timeout_err=1 and block FIFO reads until start or abort.
REQ-016 abort=1 in any state -> IDLE next edge, clearing counters and timeout_err; abort has priority over start, completion and timeout.
REQ-017 frame_done SHALL be 1 for exactly the first cycle in DONE; busy = (state==RUN or state==DRAIN).

Reset
REQ-018 reset_n=0 SHALL asynchronously force state=IDLE, in_count=0, out_count=0, watchdog=0, frame_done=0, timeout_err=0, busy=0; fifo_empty_gated=1.
REQ-019 reset mid-frame SHALL discard the frame; no frame_done is produced after release.

Verification (IN_PIXELS=16, OUT_PIXELS=4, TIMEOUT_CYC=8)
REQ-020 FIFO never empty, reader reads every cycle, start pulse -> exactly 16 rd_fire, fifo_empty_gated=1 from the 17th cycle, state=DRAIN.
REQ-021 4 out_fire during DRAIN -> state=DONE, frame_done high exactly one cycle, out_count=4, busy=0.
REQ-022 4 out_fire during RUN, then the 16th read -> DRAIN for one cycle, then DONE; a 5th out_fire in DONE leaves out_count=4.
REQ-023 after 5 reads, fifo_empty_in=1 and no out_fire for 8 cycles -> state=ERR, timeout_err=1, fifo_empty_gated=1; start -> RUN with counters 0.
REQ-024 abort and start together in RUN with in_count=7 -> IDLE, counters 0; start next cycle -> RUN.
REQ-025 reset_n low in DRAIN -> all outputs at reset values immediately, without waiting for a clock edge.
